topk_drain: RTL and testbench
=============================

// Module: topk_drain
// PURPOSE
//   Streaming top-K collector with an ordered read-out port. Accepts a value stream,
//   keeps the K largest values seen (duplicates kept) in a descending-sorted register array,
//   and on request drains them largest-first over a valid/ready port.
//   Downstream consumer of the running max/second-max trackers in the stats path.
// PARAMETERS
//   DATA_WIDTH  32  width of data values (unsigned compare)
//   K           4   number of retained values; K >= 2
// PORTS
//   clk        in   1                  clock, all state on rising edge
//   resetn     in   1                  reset, asynchronous, active-low
//   in_valid   in   1                  din is valid this cycle
//   in_ready   out  1                  block accepts din (high only in COLLECT)
//   din        in   DATA_WIDTH         input value
//   drain_req  in   1                  single-cycle request to start draining
//   out_valid  out  1                  dout valid (high only in DRAIN)
//   out_ready  in   1                  consumer accepts dout
//   dout       out  DATA_WIDTH         current largest retained value
//   out_last   out  1                  this beat is the final one of the drain
//   count      out  $clog2(K+1)        number of occupied slots
// BEHAVIOUR
//   Reset (async assert, sync release): state=COLLECT; all slots 0; count=0;
//     out_valid=0, out_last=0, dout=0, in_ready=1.
//   FSM:
//     COLLECT -> DRAIN when drain_req && (count!=0 || in_valid); otherwise drain_req is ignored.
//     DRAIN -> COLLECT on the handshake (out_valid && out_ready && out_last).
//   Insert (COLLECT, in_valid): din goes at the first index i with din > slot[i]
//     (strict compare, so an equal value lands after existing equals). Slots i..K-2 shift
//     down one; the old slot[K-1] is discarded.
//     - count < K: din always fits; count increments.
//     - count == K: din is written only if din > slot[K-1]; otherwise it is dropped
//       (still handshaken, in_ready=1). count stays K.
//     - Slots >= count are invalid and never compared against.
//   Simultaneous in_valid and drain_req in COLLECT: the insert happens in that cycle and
//     the drain includes it. The first out_valid appears the next cycle.
//   Latency: drain_req at cycle t -> out_valid=1 at t+1.
//     Insert at cycle t -> visible in count at t+1.
//   DRAIN:
//     - out_valid=1; dout=slot[0]; out_last=(count==1); in_ready=0.
//     - in_valid is not accepted.
//     - On out_valid && out_ready: slots shift up one, vacated slot[K-1]=0, count decrements.
//     - Last handshake: count=0, return to COLLECT, all slots 0.
//     - out_ready low: dout, out_valid and out_last hold stable (AXI-style, no retraction).
//     - drain_req during DRAIN is ignored.
//   Outputs are driven straight from registers; no combinational path from inputs to outputs.
//   Reset asserted mid-drain: everything returns to reset values immediately and the
//     partial drain is lost.
// STRUCTURE
//   Package topk_pkg: typedef enum logic {COLLECT, DRAIN} topk_state_e; localparam CNT_W.
//   Sub-module topk_slot (one per index): holds a value plus a valid bit. Inputs are
//     ins_here, shift_in (from the neighbour above), shift_up (from the neighbour below)
//     and clear. It emits din > value for the insertion-position priority logic in
//     topk_drain. The top level holds the FSM, count and the first-greater priority encode.
// TESTING (K=4, DATA_WIDTH=8)
//   1. Insert 5,9,3,9,7,1, then drain_req with out_ready=1 ->
//      beats 9,9,7,5; out_last on 5; count=0; 1 dropped.
//   2. Insert 2,8, then drain ->
//      beats 8,2, out_last on 2; in_ready back to 1 the cycle after.
//   3. Drain of 9,6,4 with out_ready held low 3 cycles on the first beat ->
//      dout=9 and out_valid=1 stable throughout; order unaffected.
//   4. Boundaries:
//      - drain_req with count=0, in_valid=0 -> ignored, out_valid stays 0.
//      - drain_req && in_valid din=4 with count=0 -> single beat 4, out_last=1.
//   5. in_valid pulses din=200 during DRAIN -> in_ready=0; 200 never appears;
//      count unchanged by it.
//   6. resetn low for 1 cycle after 2 beats of a 4-entry drain ->
//      out_valid=0, count=0 at once; a new insert of 3 then drain -> single beat 3.

Source files
------------

// File: rtl/topk_pkg.sv
// Shared types and sizing helpers for the top-K collector.
package topk_pkg;

  typedef enum logic {COLLECT, DRAIN} topk_state_e;

  localparam int unsigned K_DEF = 4;

  function automatic int unsigned cnt_w(input int unsigned k);
    return $clog2(k + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_w(K_DEF);

endpackage

// File: rtl/topk_if.sv
// Input stream, drain request and ordered read-out port of the top-K collector.
interface topk_if
  import topk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K          = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   din;
  logic                    drain_req;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    out_last;
  logic [cnt_w(K)-1:0]     count;

  modport master (
    output in_valid, din, drain_req, out_ready,
    input  in_ready, out_valid, dout, out_last, count
  );

  modport slave (
    input  in_valid, din, drain_req, out_ready,
    output in_ready, out_valid, dout, out_last, count
  );

endinterface

// File: rtl/topk_slot.sv
// One entry of the sorted array: value plus valid bit, loadable from din or either neighbour.
module topk_slot #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ins_here,
  input  logic                  shift_in,
  input  logic [DATA_WIDTH-1:0] above_val,
  input  logic                  above_vld,
  input  logic                  shift_up,
  input  logic [DATA_WIDTH-1:0] below_val,
  input  logic                  below_vld,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  vld,
  output logic                  din_gt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
      vld   <= 1'b0;
    end else if (clear) begin
      value <= '0;
      vld   <= 1'b0;
    end else if (ins_here) begin
      value <= din;
      vld   <= 1'b1;
    end else if (shift_in) begin
      value <= above_val;
      vld   <= above_vld;
    end else if (shift_up) begin
      value <= below_val;
      vld   <= below_vld;
    end
  end

  assign din_gt = din > value;

endmodule

// File: rtl/topk_drain.sv
// Streaming top-K collector: keeps the K largest values sorted descending, drains largest-first.
module topk_drain
  import topk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K          = 4
) (
  input  logic   clk,
  input  logic   resetn,
  topk_if.slave  bus
);

  localparam int unsigned CntW = cnt_w(K);
  localparam logic [CntW-1:0] CntFull = CntW'(K);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  topk_state_e           state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] val [K];
  logic [K-1:0]          vld, gt, sel, take_above;
  logic                  ins, pop, last_pop, seen;

  assign ins      = (state_q == COLLECT) && bus.in_valid;
  assign pop      = (state_q == DRAIN) && bus.out_ready;
  assign last_pop = pop && (count_q == CntOne);

  // First slot that is empty or smaller than din wins; everything after it shifts down.
  always_comb begin
    seen       = 1'b0;
    sel        = '0;
    take_above = '0;
    for (int i = 0; i < K; i++) begin
      take_above[i] = seen;
      sel[i]        = ins && (!vld[i] || gt[i]) && !seen;
      seen          = seen | sel[i];
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] above_val, below_val;
    logic                  above_vld, below_vld;

    if (i == 0) begin : g_first
      assign above_val = '0;
      assign above_vld = 1'b0;
    end else begin : g_mid_a
      assign above_val = val[i-1];
      assign above_vld = vld[i-1];
    end

    if (i == K - 1) begin : g_last
      assign below_val = '0;
      assign below_vld = 1'b0;
    end else begin : g_mid_b
      assign below_val = val[i+1];
      assign below_vld = vld[i+1];
    end

    topk_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .din       (bus.din),
      .ins_here  (sel[i]),
      .shift_in  (take_above[i]),
      .above_val (above_val),
      .above_vld (above_vld),
      .shift_up  (pop && !last_pop),
      .below_val (below_val),
      .below_vld (below_vld),
      .clear     (last_pop),
      .value     (val[i]),
      .vld       (vld[i]),
      .din_gt    (gt[i])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      COLLECT: begin
        if (ins && (count_q != CntFull)) count_d = count_q + CntOne;
        if (bus.drain_req && ((count_q != '0) || bus.in_valid)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop) count_d = count_q - CntOne;
        if (last_pop) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= COLLECT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_last  = (state_q == DRAIN) && (count_q == CntOne);
  assign bus.dout      = val[0];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_topk_drain.sv
// Self-checking bench for topk_drain (K=4, DATA_WIDTH=8): table-driven drains plus corner sequences.
module tb_topk_drain;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  topk_if #(.DATA_WIDTH(8), .K(4)) bus ();

  topk_drain #(.DATA_WIDTH(8), .K(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int         n_in;
    logic [7:0] ins [6];
    int         n_out;
    logic [7:0] exp [4];
    int         stall;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic insert(input logic [7:0] v);
    chk("in_ready_on_insert", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.din      = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Consumes beats for everything queued in exp_q, stalling the first beat when asked.
  task automatic collect(input int stall);
    int cyc = 0;
    int st  = stall;
    while (exp_q.size() > 0 && cyc < 40) begin
      chk("out_valid", 32'(bus.out_valid), 1);
      chk("dout", 32'(bus.dout), 32'(exp_q[0]));
      chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
      if (st > 0) begin
        bus.out_ready = 1'b0;
        st--;
      end else begin
        bus.out_ready = 1'b1;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    bus.out_ready = 1'b0;
    chk("post_out_valid", 32'(bus.out_valid), 0);
    chk("post_in_ready", 32'(bus.in_ready), 1);
    chk("post_count", 32'(bus.count), 0);
  endtask

  task automatic request_drain();
    bus.drain_req = 1'b1;
    @(negedge clk);
    bus.drain_req = 1'b0;
  endtask

  initial begin
    vecs[0] = '{n_in: 6, ins: '{5, 9, 3, 9, 7, 1}, n_out: 4, exp: '{9, 9, 7, 5}, stall: 0};
    vecs[1] = '{n_in: 2, ins: '{2, 8, 0, 0, 0, 0}, n_out: 2, exp: '{8, 2, 0, 0}, stall: 0};
    vecs[2] = '{n_in: 3, ins: '{9, 6, 4, 0, 0, 0}, n_out: 3, exp: '{9, 6, 4, 0}, stall: 3};
    vecs[3] = '{n_in: 6, ins: '{1, 1, 1, 1, 1, 2}, n_out: 4, exp: '{2, 1, 1, 1}, stall: 1};
    vecs[4] = '{n_in: 5, ins: '{3, 3, 3, 3, 3, 0}, n_out: 4, exp: '{3, 3, 3, 3}, stall: 0};

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.drain_req = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_count", 32'(bus.count), 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n_in; i++) insert(vecs[v].ins[i]);
      chk("count_after_inserts", 32'(bus.count), 32'(vecs[v].n_out));
      for (int i = 0; i < vecs[v].n_out; i++) exp_q.push_back(vecs[v].exp[i]);
      request_drain();
      collect(vecs[v].stall);
    end

    // Empty drain request is ignored.
    request_drain();
    chk("empty_drain_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("empty_drain_valid2", 32'(bus.out_valid), 0);
    chk("empty_drain_ready", 32'(bus.in_ready), 1);

    // Insert and drain request in the same cycle.
    bus.in_valid  = 1'b1;
    bus.din       = 8'd4;
    bus.drain_req = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.drain_req = 1'b0;
    exp_q.push_back(8'd4);
    collect(0);

    // in_valid during DRAIN is refused.
    insert(8'd7);
    insert(8'd5);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd5);
    request_drain();
    chk("drain_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid  = 1'b1;
    bus.din       = 8'd200;
    bus.out_ready = 1'b0;
    bus.drain_req = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.drain_req = 1'b0;
    chk("drain_count_hold", 32'(bus.count), 2);
    chk("drain_dout_hold", 32'(bus.dout), 7);
    collect(0);

    // Reset asserted mid-drain.
    insert(8'd8);
    insert(8'd6);
    insert(8'd4);
    insert(8'd2);
    request_drain();
    bus.out_ready = 1'b1;
    chk("pre_rst_beat0", 32'(bus.dout), 8);
    @(negedge clk);
    chk("pre_rst_beat1", 32'(bus.dout), 6);
    @(negedge clk);
    chk("pre_rst_count", 32'(bus.count), 2);
    bus.out_ready = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    insert(8'd3);
    exp_q.push_back(8'd3);
    request_drain();
    collect(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
